// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage RAM access controller.
//   SIZE_*         : request size encodings (size 2'b11 is illegal)
//   LAT_*          : supported RAM read latencies
//   state_t        : controller FSM states
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int LAT_HIGH_PERFORMANCE = 2;
    localparam int LAT_LOW_LATENCY      = 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane logic shared by the load path and the
// read-modify-write store path.
// Ports:
//   word      in  32  word read from RAM
//   size      in  2   access size (byte / half / word)
//   lane      in  2   byte address bits [1:0]
//   is_signed in  1   sign-extend sub-word loads when 1
//   wdata     in  32  store data, right-justified
//   load_data out 32  extracted and extended load result
//   merged    out 32  word with the addressed lane replaced by wdata
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v    = word[{lane, 3'b000} +: 8];
        half_v    = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{is_signed & byte_v[7]}}, byte_v};
                merged    = word;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{is_signed & half_v[15]}}, half_v};
                merged    = lane[1] ? {wdata[15:0], word[15:0]}
                                    : {word[31:16], wdata[15:0]};
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// MEM-stage initiator for a single-port read-first data RAM. Accepts one
// load/store at a time, waits out the RAM read latency, performs sub-word
// stores as read-modify-write and reports misaligned / out-of-range /
// illegal-size requests without touching the RAM.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake; req_write, req_size, req_signed,
//   req_addr (byte address), req_wdata (right-justified)
//   resp_valid (1-cycle pulse), resp_rdata, resp_error
//   ram_addr, ram_dataIn, ram_we, ram_enable, ram_re, ram_reset, ram_dataOut
module ram_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int RAM_WIDTH    = 32,
    parameter int RAM_DEPTH    = 17,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [RAM_WIDTH-1:0]  req_wdata,
    output logic                  resp_valid,
    output logic [RAM_WIDTH-1:0]  resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]  ram_dataIn,
    output logic                  ram_we,
    output logic                  ram_enable,
    output logic                  ram_re,
    output logic                  ram_reset,
    input  logic [RAM_WIDTH-1:0]  ram_dataOut
);

    // Anything other than the low-latency setting runs as high-performance.
    localparam int LAT_EFF = (READ_LATENCY == LAT_LOW_LATENCY) ? LAT_LOW_LATENCY
                                                                : LAT_HIGH_PERFORMANCE;
    localparam logic [1:0] WAIT_LOAD = 2'(LAT_EFF - 1);

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   wr_q, sgn_q, err_q;
    logic [1:0]             size_q, lane_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [RAM_WIDTH-1:0]   wdata_q, rdata_q;

    logic                   accept, capture;
    logic [ADDR_WIDTH-1:0]  req_word;
    logic                   req_range_err, req_align_err, req_err;
    logic [31:0]            load_data, merged;

    assign ram_reset = ~reset;
    assign ram_addr  = addr_q;
    assign accept    = (state_q == IDLE) && req_valid;

    // Request validation, evaluated on the incoming (not yet latched) fields.
    assign req_word      = req_addr[ADDR_WIDTH+1:2];
    assign req_range_err = (|req_addr[31:ADDR_WIDTH+2]) || (int'(req_word) >= RAM_DEPTH);
    assign req_err       = req_range_err || req_align_err;

    always_comb begin
        req_align_err = 1'b0;
        case (req_size)
            SIZE_BYTE: req_align_err = 1'b0;
            SIZE_HALF: req_align_err = req_addr[0];
            SIZE_WORD: req_align_err = |req_addr[1:0];
            default:   req_align_err = 1'b1;
        endcase
    end

    mem_lane_align u_lane (
        .word      (rdata_q),
        .size      (size_q),
        .lane      (lane_q),
        .is_signed (sgn_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                sgn_q   <= req_signed;
                err_q   <= req_err;
                size_q  <= req_size;
                lane_q  <= req_addr[1:0];
                addr_q  <= req_word;
                wdata_q <= req_wdata;
            end
            if (capture) begin
                rdata_q <= ram_dataOut;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_error = 1'b0;
        ram_enable = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_dataIn = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && (req_size == SIZE_WORD))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                ram_enable = 1'b1;
                ram_re     = 1'b1;
                cnt_d      = WAIT_LOAD;
                state_d    = WAIT;
            end
            WAIT: begin
                ram_re = 1'b1;
                if (cnt_q == 2'd0) begin
                    // RAM output is valid during the last WAIT cycle.
                    capture = 1'b1;
                    state_d = wr_q ? WRITE : RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WRITE: begin
                ram_enable = 1'b1;
                ram_we     = 1'b1;
                // Word stores come straight through the merge unchanged.
                ram_dataIn = merged;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (err_q || wr_q) ? '0 : load_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Memory-side initiator that turns MIPS load/store requests from the MEM stage into access sequences for the single-port read-first data RAM. It accepts one request at a time over a valid/ready handshake and waits out the RAM's configurable read latency. Byte and halfword stores have no RAM byte-enables, so it performs them as read-modify-write. It returns load data aligned and sign/zero-extended, and flags misaligned or out-of-range accesses without touching the RAM.

Parameters:
RAM_WIDTH, 32, data width; fixed 32 for MIPS lane logic
RAM_DEPTH, 17, number of RAM words; accesses to word index >= RAM_DEPTH are errors
ADDR_WIDTH, 5, RAM word-address width, equal to clogb2(RAM_DEPTH-1)
READ_LATENCY, 2, RAM read latency in cycles: 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY; other values illegal

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (error)
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for sub-word sizes
resp_valid  out  1  one-cycle completion pulse; no back-pressure
resp_rdata  out  32  load result; 0 for stores and errors
resp_error  out  1  valid with resp_valid: misaligned, out of range, or illegal size
ram_addr  out  ADDR_WIDTH  RAM word address = latched req_addr[ADDR_WIDTH+1:2]
ram_dataIn  out  32  RAM write data
ram_we  out  1  RAM write enable
ram_enable  out  1  RAM port enable
ram_re  out  1  RAM output-register enable
ram_reset  out  1  RAM output reset = NOT reset (combinational)
ram_dataOut  in  32  RAM read data

Behaviour:
- Reset (asserted low, async): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_error=0; ram_we=ram_enable=ram_re=0; ram_addr=0; ram_dataIn=0; latched request cleared.
- Handshake: a request is accepted on an edge where req_valid and req_ready are both 1. All request fields are latched at accept. req_ready is 0 in every other state, so a held req_valid is never accepted twice.
- Error check at accept: halfword needs addr[0]=0, word needs addr[1:0]=00, size 11 is illegal, and addr[31:ADDR_WIDTH+2] must be 0 with word index < RAM_DEPTH. Error path goes IDLE -> RESP with resp_error=1 and generates no RAM enable/we.
- States: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE -> WRITE for a word store; IDLE -> READ for a load or sub-word store.
  - READ: ram_enable=1, we=0, ram_re=1 for one cycle -> WAIT.
  - WAIT: ram_re=1 and ram_enable=0 for exactly READ_LATENCY cycles (down-counter). ram_dataOut is captured at the end of the last WAIT cycle. Load -> RESP; sub-word store -> WRITE.
  - WRITE: ram_enable=1, ram_we=1, ram_dataIn = word (or merged word) for one cycle -> RESP.
  - RESP: resp_valid=1 for one cycle -> IDLE, req_ready=1 next cycle.
- ram_addr is held constant from accept until return to IDLE.
- Latency from accept edge T0 to resp_valid cycle:
  - error: T1
  - word store: T2
  - load: T(2+READ_LATENCY)
  - sub-word store: T(3+READ_LATENCY)
- Lanes (little-endian): byte lane = addr[1:0]; half lane = addr[1].
  - Load extracts the lane and sign- or zero-extends per req_signed. Word loads ignore req_signed.
  - Sub-word store replaces only the addressed lane in the captured word; other bytes are preserved exactly.
- resp_rdata and resp_error are valid only while resp_valid=1 and are 0 otherwise.
- Reset mid-operation: the access is abandoned immediately and no response is produced. A store not yet in WRITE never reaches RAM. RAM contents are not restored.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - state enum (IDLE, READ, WAIT, WRITE, RESP)
  - constants LAT_HIGH_PERFORMANCE=2, LAT_LOW_LATENCY=1
- One combinational sub-module, mem_lane_align, contains the lane extraction with sign/zero-extension and the store merge. It is reused by the load path and the RMW path.
- The FSM, counter and handshake stay in ram_access_ctrl.

Test Plan:
1. Word store then load (RAM model, READ_LATENCY=2): SW 0x08 data 0xDEADBEEF, then LW 0x08 -> store resp at T2, load resp at T4, rdata=0xDEADBEEF, ram_addr=2, exactly one we pulse.
2. Byte RMW: SB 0x09 wdata 0x000000AA on that word -> RAM word 0xDEADAAEF, resp at T5. Then LB 0x09 signed -> 0xFFFFFFAA; LBU -> 0x000000AA.
3. Halfword: LH 0x0A signed -> 0xFFFFDEAD. LH 0x0B -> resp_error=1 at T1, rdata=0, no ram_enable.
4. Range and size errors: LW 0x44 (word 17) -> error. LW 0x80000000 -> error. size=11 -> error. RAM is never enabled in any case.
5. Reset during WAIT of SH 0x0C wdata 0x1234 -> outputs go to reset values at once, no resp_valid, ram_we never asserted, word 0x0C unchanged. Bench then holds req_valid high across a busy period -> the request is accepted exactly once.
6. READ_LATENCY=1 build: LW -> resp at T3; SB -> resp at T4; back-to-back requests accepted the cycle after each resp.
